maindec_pipe: RTL and testbench
===============================

Name: maindec_pipe

Overview:
Registered, flow-controlled successor to the combinational main decoder. Accepts an 11-bit LEGv8 opcode through a valid/ready handshake, decodes it, and holds the control bundle in a DEPTH-entry output queue for the datapath. Adds CBNZ, B, ADDI and SUBI decoding (gated by a parameter), illegal-opcode flagging, flush, and saturating decode and illegal counters. Sits between instruction fetch and the execute-stage control registers.

Parameters:
EXT_OPS, 1, 1 enables decoding of CBNZ, B, ADDI and SUBI; 0 treats them as illegal.
DEPTH, 2, output queue entries; power of two, at least 2.
CNT_W, 16, width of the decode and illegal counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  synchronous; discards all queued entries.
in_valid  in  1  Op is valid this cycle.
in_ready  out  1  the queue can accept an opcode.
Op  in  11  opcode, instruction bits [31:21].
out_valid  out  1  queue head is valid.
out_ready  in  1  consumer takes the head this cycle.
Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchZero, Uncond, Illegal  out  1 each  control bits of the queue head.
ALUOp  out  2  ALU operation class of the queue head.
dec_count  out  CNT_W  number of accepted opcodes.
ill_count  out  CNT_W  number of accepted illegal opcodes.

Behaviour:
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = !full || out_ready. A simultaneous push and pop on a full queue is allowed.
- Latency: an opcode accepted in cycle N is visible at the queue head in cycle N+1 when the queue is empty. There is no combinational path from Op to the outputs.
- Decode table, listed as Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchZero, Uncond, ALUOp:
  - LDUR 11111000010: 0 1 1 1 1 0 0 0 0, ALUOp 00
  - STUR 11111000000: 1 1 0 0 0 1 0 0 0, ALUOp 00
  - R-format (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): 0 0 0 1 0 0 0 0 0, ALUOp 10
  - CBZ 10110100xxx: 1 0 0 0 0 0 1 1 0, ALUOp 01
  - CBNZ 10110101xxx (EXT_OPS only): 1 0 0 0 0 0 1 0 0, ALUOp 01
  - B 000101xxxxx (EXT_OPS only): 0 0 0 0 0 0 0 0 1, ALUOp 01
  - ADDI 1001000100x and SUBI 1101000100x (EXT_OPS only): 0 1 0 1 0 0 0 0 0, ALUOp 10
  - Anything else: all control bits 0, ALUOp 00, Illegal=1.
- Queue: circular buffer with read and write pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
  - full = (count == DEPTH); out_valid = (count != 0).
- When out_valid=0, all control outputs read 0.
- Flush: next state is count=0 and both pointers=0. An accept in the same cycle as flush is dropped and not counted. Counters are not affected by flush.
- Counters:
  - dec_count increments on every accept; ill_count increments on every accept where Illegal=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (asynchronous assert, active-low): count, pointers and both counters go to 0, so out_valid=0, every control output is 0, and in_ready=1. A reset in mid-stream discards all queued entries.
- Opcode bits are 2-state; X on Op while in_valid=0 is ignored.

Decomposition:
- Package legv8_pkg:
  - opcode constants and match masks (OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ_M, OP_CBNZ_M, OP_B_M, OP_ADDI_M, OP_SUBI_M);
  - the packed struct ctrl_t containing the nine control bits, ALUOp and Illegal;
  - the ALUOp constants ALU_MEM=00, ALU_BR=01, ALU_R=10.
- Sub-module maindec_comb: purely combinational, maps Op to ctrl_t, parameterised by EXT_OPS. It is instantiated once at the queue input and is reusable elsewhere.

Test Plan:
1. Reset low, then high. Push LDUR 11111000010 with out_ready=1. Next cycle: out_valid=1, ALUSrc=MemtoReg=RegWrite=MemRead=1, ALUOp=00, dec_count=1.
2. Hold out_ready=0 and push STUR, ADD 10001011000 and CBZ 10110100101 with DEPTH=2. in_ready drops after two accepts; the third is held. Pop sequence: STUR (Reg2Loc=1, MemWrite=1), then ADD (ALUOp=10), then CBZ (Branch=BranchZero=1).
3. EXT_OPS=1: CBNZ 10110101011 gives Branch=1, BranchZero=0; B 00010100000 gives Uncond=1; ADDI 10010001000 gives ALUSrc=1, RegWrite=1, ALUOp=10. EXT_OPS=0: the same three opcodes give Illegal=1 with all other controls 0, and ill_count=3.
4. Push 11111111111: Illegal=1, ill_count increments, dec_count increments.
5. Fill the queue, then assert flush together with in_valid. Next cycle: out_valid=0, in_ready=1, counters unchanged from before the flush.
6. CNT_W=4: 20 accepts leave dec_count at 15. Asserting reset mid-stream with entries queued drops out_valid and both counters to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/legv8_pkg.sv
// LEGv8 main-decoder shared definitions: opcode values, match masks and the control bundle.
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;

  // Partially-decoded opcodes: *_V is the value, *_M marks the bits that must match.
  localparam logic [10:0] OP_CBZ_V  = 11'b101_1010_0000;
  localparam logic [10:0] OP_CBZ_M  = 11'b111_1111_1000;
  localparam logic [10:0] OP_CBNZ_V = 11'b101_1010_1000;
  localparam logic [10:0] OP_CBNZ_M = 11'b111_1111_1000;
  localparam logic [10:0] OP_B_V    = 11'b000_1010_0000;
  localparam logic [10:0] OP_B_M    = 11'b111_1110_0000;
  localparam logic [10:0] OP_ADDI_V = 11'b100_1000_1000;
  localparam logic [10:0] OP_ADDI_M = 11'b111_1111_1110;
  localparam logic [10:0] OP_SUBI_V = 11'b110_1000_1000;
  localparam logic [10:0] OP_SUBI_M = 11'b111_1111_1110;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  typedef struct packed {
    logic       reg2loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_zero;
    logic       uncond;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == (val & mask);
  endfunction

endpackage

// File: rtl/maindec_comb.sv
// Combinational LEGv8 main decoder; extended opcodes are flagged illegal when EXT_OPS is 0.
module maindec_comb
  import legv8_pkg::*;
#(
  parameter bit EXT_OPS = 1'b1
) (
  input  logic [10:0] op_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (op_i == OP_LDUR) begin
      ctrl_o.alu_src    = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
      ctrl_o.reg_write  = 1'b1;
      ctrl_o.mem_read   = 1'b1;
      ctrl_o.alu_op     = ALU_MEM;
    end else if (op_i == OP_STUR) begin
      ctrl_o.reg2loc   = 1'b1;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.mem_write = 1'b1;
      ctrl_o.alu_op    = ALU_MEM;
    end else if (op_i == OP_ADD || op_i == OP_SUB || op_i == OP_AND || op_i == OP_ORR) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_R;
    end else if (op_match(op_i, OP_CBZ_V, OP_CBZ_M)) begin
      ctrl_o.reg2loc     = 1'b1;
      ctrl_o.branch      = 1'b1;
      ctrl_o.branch_zero = 1'b1;
      ctrl_o.alu_op      = ALU_BR;
    end else if (EXT_OPS && op_match(op_i, OP_CBNZ_V, OP_CBNZ_M)) begin
      ctrl_o.reg2loc = 1'b1;
      ctrl_o.branch  = 1'b1;
      ctrl_o.alu_op  = ALU_BR;
    end else if (EXT_OPS && op_match(op_i, OP_B_V, OP_B_M)) begin
      ctrl_o.uncond = 1'b1;
      ctrl_o.alu_op = ALU_BR;
    end else if (EXT_OPS && (op_match(op_i, OP_ADDI_V, OP_ADDI_M) ||
                             op_match(op_i, OP_SUBI_V, OP_SUBI_M))) begin
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_R;
    end else begin
      ctrl_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/maindec_pipe.sv
// Registered main decoder: valid/ready input, DEPTH-entry control queue, saturating counters.
module maindec_pipe
  import legv8_pkg::*;
#(
  parameter bit          EXT_OPS = 1'b1,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             BranchZero,
  output logic             Uncond,
  output logic             Illegal,
  output logic [1:0]       ALUOp,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [CNT_W-1:0] dec_q, dec_d, ill_q, ill_d;
  ctrl_t            mem_q [DEPTH];
  ctrl_t            dec_ctrl, head;
  logic             full, push, pop;

  maindec_comb #(
    .EXT_OPS(EXT_OPS)
  ) u_dec (
    .op_i  (Op),
    .ctrl_o(dec_ctrl)
  );

  assign full      = (count_q == (PtrW + 1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign in_ready  = !full || out_ready;
  // Flush drops a same-cycle accept entirely, including from the counters.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dec_d    = dec_q;
    ill_d    = ill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + (PtrW + 1)'(1);
      else if (!push && pop) count_d = count_q - (PtrW + 1)'(1);
    end
    if (push && (dec_q != {CNT_W{1'b1}})) dec_d = dec_q + CNT_W'(1);
    if (push && dec_ctrl.illegal && (ill_q != {CNT_W{1'b1}})) ill_d = ill_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dec_q    <= '0;
      ill_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dec_q    <= dec_d;
      ill_q    <= ill_d;
    end
  end

  // Storage needs no reset: entries are only observable while out_valid is set.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_ctrl;
  end

  assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign Reg2Loc    = head.reg2loc;
  assign ALUSrc     = head.alu_src;
  assign MemtoReg   = head.mem_to_reg;
  assign RegWrite   = head.reg_write;
  assign MemRead    = head.mem_read;
  assign MemWrite   = head.mem_write;
  assign Branch     = head.branch;
  assign BranchZero = head.branch_zero;
  assign Uncond     = head.uncond;
  assign ALUOp      = head.alu_op;
  assign Illegal    = head.illegal;
  assign dec_count  = dec_q;
  assign ill_count  = ill_q;

endmodule

// File: tb/tb_maindec_pipe.sv
// Bench for maindec_pipe: default, EXT_OPS=0 and CNT_W=4 instances share one stimulus stream.
module tb_maindec_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [10:0] op;

  // Control bits packed as {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,
  // Branch,BranchZero,Uncond,ALUOp[1:0],Illegal}.
  logic [11:0] a_ctrl, n_ctrl, c_ctrl;
  logic        a_ir, a_ov, n_ir, n_ov, c_ir, c_ov;
  logic [15:0] a_dec, a_ill, n_dec, n_ill;
  logic [3:0]  c_dec, c_ill;

  always #5 clk = ~clk;

  maindec_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_ir), .Op(op),
    .out_valid(a_ov), .out_ready(out_ready), .Reg2Loc(a_ctrl[11]), .ALUSrc(a_ctrl[10]),
    .MemtoReg(a_ctrl[9]), .RegWrite(a_ctrl[8]), .MemRead(a_ctrl[7]), .MemWrite(a_ctrl[6]),
    .Branch(a_ctrl[5]), .BranchZero(a_ctrl[4]), .Uncond(a_ctrl[3]), .Illegal(a_ctrl[0]),
    .ALUOp(a_ctrl[2:1]), .dec_count(a_dec), .ill_count(a_ill)
  );

  maindec_pipe #(.EXT_OPS(1'b0)) dut_ne (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_ir), .Op(op),
    .out_valid(n_ov), .out_ready(out_ready), .Reg2Loc(n_ctrl[11]), .ALUSrc(n_ctrl[10]),
    .MemtoReg(n_ctrl[9]), .RegWrite(n_ctrl[8]), .MemRead(n_ctrl[7]), .MemWrite(n_ctrl[6]),
    .Branch(n_ctrl[5]), .BranchZero(n_ctrl[4]), .Uncond(n_ctrl[3]), .Illegal(n_ctrl[0]),
    .ALUOp(n_ctrl[2:1]), .dec_count(n_dec), .ill_count(n_ill)
  );

  maindec_pipe #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_ir), .Op(op),
    .out_valid(c_ov), .out_ready(out_ready), .Reg2Loc(c_ctrl[11]), .ALUSrc(c_ctrl[10]),
    .MemtoReg(c_ctrl[9]), .RegWrite(c_ctrl[8]), .MemRead(c_ctrl[7]), .MemWrite(c_ctrl[6]),
    .Branch(c_ctrl[5]), .BranchZero(c_ctrl[4]), .Uncond(c_ctrl[3]), .Illegal(c_ctrl[0]),
    .ALUOp(c_ctrl[2:1]), .dec_count(c_dec), .ill_count(c_ill)
  );

  localparam logic [11:0] C_LDUR = 12'b0111_1000_0000;
  localparam logic [11:0] C_STUR = 12'b1100_0100_0000;
  localparam logic [11:0] C_R    = 12'b0001_0000_0100;
  localparam logic [11:0] C_CBZ  = 12'b1000_0011_0010;
  localparam logic [11:0] C_CBNZ = 12'b1000_0010_0010;
  localparam logic [11:0] C_B    = 12'b0000_0000_1010;
  localparam logic [11:0] C_IMM  = 12'b0101_0000_0100;
  localparam logic [11:0] C_ILL  = 12'b0000_0000_0001;

  typedef struct {
    logic [10:0] op;
    logic [11:0] e;    // expected with EXT_OPS=1
    logic [11:0] ene;  // expected with EXT_OPS=0
  } vec_t;

  vec_t        vecs[17];
  logic [11:0] mq_e[$];
  logic [11:0] mq_n[$];
  int          exp_dec, exp_ill, exp_ill_ne;
  int          n_cmp, n_err;

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic ordy);
    logic [11:0] he, hn;
    logic        ov;
    ov = (mq_e.size() != 0);
    he = ov ? mq_e[0] : 12'h0;
    hn = ov ? mq_n[0] : 12'h0;
    chk("in_ready",      32'(a_ir), 32'(mq_e.size() < 2 || ordy));
    chk("out_valid",     32'(a_ov), 32'(ov));
    chk("ctrl",          32'(a_ctrl), 32'(he));
    chk("ctrl_noext",    32'(n_ctrl), 32'(hn));
    chk("ctrl_c4",       32'(c_ctrl), 32'(he));
    chk("out_valid_ne",  32'(n_ov), 32'(ov));
    chk("dec_count",     32'(a_dec), 32'(exp_dec));
    chk("ill_count",     32'(a_ill), 32'(exp_ill));
    chk("ill_count_ne",  32'(n_ill), 32'(exp_ill_ne));
    chk("dec_count_ne",  32'(n_dec), 32'(exp_dec));
    chk("dec_count_c4",  32'(c_dec), 32'(sat15(exp_dec)));
    chk("ill_count_c4",  32'(c_ill), 32'(sat15(exp_ill)));
  endtask

  task automatic cycle(input logic v, input logic [10:0] o, input logic [11:0] e,
                       input logic [11:0] ene, input logic ordy, input logic fl);
    logic acc, pp;
    in_valid  = v;
    op        = v ? o : 11'bx;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_outputs(ordy);
    acc = v && (mq_e.size() < 2 || ordy);
    pp  = (mq_e.size() != 0) && ordy;
    @(posedge clk);
    if (fl) begin
      mq_e.delete();
      mq_n.delete();
    end else begin
      if (pp) begin
        void'(mq_e.pop_front());
        void'(mq_n.pop_front());
      end
      if (acc) begin
        mq_e.push_back(e);
        mq_n.push_back(ene);
        exp_dec++;
        if (e[0])   exp_ill++;
        if (ene[0]) exp_ill_ne++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 11'h0, 12'h0, 12'h0, ordy, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    exp_dec = 0; exp_ill = 0; exp_ill_ne = 0;
    vecs[0]  = '{11'b11111000010, C_LDUR, C_LDUR};
    vecs[1]  = '{11'b11111000000, C_STUR, C_STUR};
    vecs[2]  = '{11'b10001011000, C_R,    C_R};
    vecs[3]  = '{11'b11001011000, C_R,    C_R};
    vecs[4]  = '{11'b10001010000, C_R,    C_R};
    vecs[5]  = '{11'b10101010000, C_R,    C_R};
    vecs[6]  = '{11'b10110100101, C_CBZ,  C_CBZ};
    vecs[7]  = '{11'b10110101011, C_CBNZ, C_ILL};
    vecs[8]  = '{11'b00010100000, C_B,    C_ILL};
    vecs[9]  = '{11'b00010111111, C_B,    C_ILL};
    vecs[10] = '{11'b10010001000, C_IMM,  C_ILL};
    vecs[11] = '{11'b10010001001, C_IMM,  C_ILL};
    vecs[12] = '{11'b11010001000, C_IMM,  C_ILL};
    vecs[13] = '{11'b11111111111, C_ILL,  C_ILL};
    vecs[14] = '{11'b00000000000, C_ILL,  C_ILL};
    vecs[15] = '{11'b10110110000, C_ILL,  C_ILL};
    vecs[16] = '{11'b10001011001, C_ILL,  C_ILL};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single-op decode: push, then check the head one cycle later while it pops.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].op, vecs[i].e, vecs[i].ene, 1'b1, 1'b0);
      idle(1'b1);
    end

    // Backpressure: third push held while full, then push+pop on a full queue.
    cycle(1'b1, 11'b11111000000, C_STUR, C_STUR, 1'b0, 1'b0);
    cycle(1'b1, 11'b10001011000, C_R, C_R, 1'b0, 1'b0);
    cycle(1'b1, 11'b10110100101, C_CBZ, C_CBZ, 1'b0, 1'b0);
    cycle(1'b1, 11'b10110100101, C_CBZ, C_CBZ, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush on a full queue with a concurrent push.
    cycle(1'b1, 11'b11111000010, C_LDUR, C_LDUR, 1'b0, 1'b0);
    cycle(1'b1, 11'b11111111111, C_ILL, C_ILL, 1'b0, 1'b0);
    cycle(1'b1, 11'b10001011000, C_R, C_R, 1'b1, 1'b1);
    idle(1'b0);

    // Drive the 4-bit counters into saturation.
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, vecs[k % 17].op, vecs[k % 17].e, vecs[k % 17].ene, 1'b1, 1'b0);
    end
    idle(1'b1);

    // Asynchronous reset with a full queue, checked before any clock edge.
    cycle(1'b1, 11'b11111000000, C_STUR, C_STUR, 1'b0, 1'b0);
    cycle(1'b1, 11'b10001011000, C_R, C_R, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_ov), 32'd0);
    chk("rst_ctrl",      32'(a_ctrl), 32'd0);
    chk("rst_in_ready",  32'(a_ir), 32'd1);
    chk("rst_dec",       32'(a_dec), 32'd0);
    chk("rst_ill",       32'(a_ill), 32'd0);
    chk("rst_dec_c4",    32'(c_dec), 32'd0);
    chk("rst_ov_c4",     32'(c_ov), 32'd0);
    chk("rst_ir_c4",     32'(c_ir), 32'd1);
    chk("rst_ir_ne",     32'(n_ir), 32'd1);
    mq_e.delete(); mq_n.delete();
    exp_dec = 0; exp_ill = 0; exp_ill_ne = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b1, 11'b10110101011, C_CBNZ, C_ILL, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
